// File: rtl/between_to_fifo_pkg.sv
// Shared definitions for the inter-board link receive stage: FSM encoding,
// CRC-8 polynomial and the default frame terminator.
package between_to_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2,
    DONE  = 2'd3
  } rxState_t;

  localparam logic [7:0] CRC8_POLY        = 8'h07;
  localparam logic [7:0] DEFAULT_END_BYTE = 8'h0A;

endpackage

// File: rtl/between_to_fifo_crc8_byte_update.sv
// Combinational CRC-8 (poly 0x07, MSB-first) step over one byte; shared with
// the transmit-side CRC.
module crc8_byte_update
  import between_to_fifo_pkg::*;
(
  input  logic [7:0] crcIn,
  input  logic [7:0] dataIn,
  output logic [7:0] crcOut
);

  logic [7:0] acc;

  always_comb begin
    acc = crcIn ^ dataIn;
    for (int i = 0; i < 8; i++) begin
      acc = acc[7] ? ({acc[6:0], 1'b0} ^ CRC8_POLY) : {acc[6:0], 1'b0};
    end
    crcOut = acc;
  end

endmodule

// File: rtl/between_to_fifo.sv
// Receive side of the inter-board parallel link: 4-phase tsent/trecieve handshake,
// FIFO write, byte count and CRC. CRC logic is built only with BETWEEN_TO_FIFO_CRC_EN.
module between_to_fifo
  import between_to_fifo_pkg::*;
#(
  parameter logic [7:0] END_BYTE    = DEFAULT_END_BYTE,
  parameter int         SYNC_STAGES = 2,
  parameter int         COUNT_W     = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [7:0]         t_in,
  input  logic               tsent,
  output logic               trecieve,
  output logic [7:0]         fifo_data_out,
  output logic               fifo_we,
  input  logic               fifo_busy,
  input  logic               fifo_full,
  output logic [COUNT_W-1:0] byte_count,
  output logic [7:0]         crc,
  output logic               isFinish,
  output logic               proto_err
);

  rxState_t               state;
  logic [SYNC_STAGES-1:0] syncChain;
  logic                   tsentS;
  logic [7:0]             dataReg;
  logic                   writeFire;
  logic                   clearFrame;

  function automatic logic [COUNT_W-1:0] satInc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + COUNT_W'(1);
  endfunction

  // tsent is asynchronous to clk; t_in is only trusted once tsentS is high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) syncChain <= '0;
    else       syncChain <= {syncChain[SYNC_STAGES-2:0], tsent};
  end
  assign tsentS = syncChain[SYNC_STAGES-1];

  assign writeFire  = (state == WRITE) && !fifo_busy && !fifo_full;
  assign clearFrame = (state == DONE) && !enable;

  always_ff @(posedge clk) begin
    if (state == IDLE && enable && tsentS) dataReg <= t_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      trecieve      <= 1'b0;
      fifo_we       <= 1'b0;
      fifo_data_out <= 8'h00;
      byte_count    <= '0;
      isFinish      <= 1'b0;
      proto_err     <= 1'b0;
    end else begin
      fifo_we <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && tsentS) state <= WRITE;
        end
        WRITE: begin
          if (!tsentS) proto_err <= 1'b1;
          if (writeFire) begin
            fifo_we       <= 1'b1;
            fifo_data_out <= dataReg;
            byte_count    <= satInc(byte_count);
            trecieve      <= 1'b1;
            state         <= ACK;
          end
        end
        ACK: begin
          // enable is deliberately ignored here so an in-flight byte always completes
          if (!tsentS) begin
            trecieve <= 1'b0;
            if (dataReg == END_BYTE) begin
              isFinish <= 1'b1;
              state    <= DONE;
            end else begin
              state <= IDLE;
            end
          end
        end
        DONE: begin
          if (!enable) begin
            isFinish   <= 1'b0;
            byte_count <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BETWEEN_TO_FIFO_CRC_EN
  logic [7:0] crcReg;
  logic [7:0] crcNext;

  crc8_byte_update uCrc (
    .crcIn  (crcReg),
    .dataIn (dataReg),
    .crcOut (crcNext)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           crcReg <= 8'h00;
    else if (writeFire)  crcReg <= crcNext;
    else if (clearFrame) crcReg <= 8'h00;
  end
  assign crc = crcReg;
`else
  assign crc = 8'h00;
`endif

endmodule

// File: tb/tb_between_to_fifo.sv
// Scoreboard bench for between_to_fifo: directed handshakes push expected writes,
// an independent monitor checks every FIFO write against the queue.
module tb_between_to_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] t_in = 8'h00;
  logic       tsent = 1'b0;
  logic       trecieve;
  logic [7:0] fifo_data_out;
  logic       fifo_we;
  logic       fifo_busy = 1'b0;
  logic       fifo_full = 1'b0;
  logic [9:0] byte_count;
  logic [7:0] crc;
  logic       isFinish;
  logic       proto_err;

  between_to_fifo dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .t_in          (t_in),
    .tsent         (tsent),
    .trecieve      (trecieve),
    .fifo_data_out (fifo_data_out),
    .fifo_we       (fifo_we),
    .fifo_busy     (fifo_busy),
    .fifo_full     (fifo_full),
    .byte_count    (byte_count),
    .crc           (crc),
    .isFinish      (isFinish),
    .proto_err     (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [9:0] cnt;
    logic [7:0] crc;
  } exp_t;

  exp_t       q[$];
  int         tests = 0;
  int         fails = 0;
  logic [9:0] expCount = '0;
  logic [7:0] expCrc = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Remainder of (crc^byte)*x^8 modulo x^8+x^2+x+1 by long division
  function automatic logic [7:0] crcModel(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = {c ^ b, 8'h00};
    for (int k = 15; k >= 8; k--)
      if (r[k]) r = r ^ (16'h0107 << (k - 8));
    return r[7:0];
  endfunction

  task automatic expectWrite(input logic [7:0] b);
    exp_t e;
    if (expCount != 10'h3FF) expCount = expCount + 10'd1;
`ifdef BETWEEN_TO_FIFO_CRC_EN
    expCrc = crcModel(expCrc, b);
`else
    expCrc = 8'h00;
`endif
    e.data = b;
    e.cnt  = expCount;
    e.crc  = expCrc;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset && fifo_we) begin
      if (q.size() == 0) begin
        check("unexpected_write", {24'h0, fifo_data_out}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("write_data", {24'h0, fifo_data_out}, {24'h0, e.data});
        check("write_count", {22'h0, byte_count}, {22'h0, e.cnt});
        check("write_crc", {24'h0, crc}, {24'h0, e.crc});
        check("ack_with_we", {31'h0, trecieve}, 32'd1);
      end
    end
  end

  task automatic waitTrecieve(input logic val, input int budget, input string name);
    int n;
    n = 0;
    while (trecieve !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (trecieve !== val) check(name, {31'h0, trecieve}, {31'h0, val});
  endtask

  task automatic sendByte(input logic [7:0] b);
    expectWrite(b);
    @(negedge clk);
    t_in  = b;
    tsent = 1'b1;
    waitTrecieve(1'b1, 60, "ack_rise_timeout");
    tsent = 1'b0;
    waitTrecieve(1'b0, 20, "ack_fall_timeout");
    @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset  = 1'b1;
    tsent  = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    reset    = 1'b0;
    expCount = '0;
    expCrc   = 8'h00;
    enable   = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int ackHi;
    int weHi;

    #1;
    check("rst_trecieve", {31'h0, trecieve}, 32'd0);
    check("rst_we", {31'h0, fifo_we}, 32'd0);
    check("rst_count", {22'h0, byte_count}, 32'd0);
    check("rst_crc", {24'h0, crc}, 32'd0);
    check("rst_finish", {31'h0, isFinish}, 32'd0);
    check("rst_proto", {31'h0, proto_err}, 32'd0);
    doReset();

    // Single byte with latency measurement
    expectWrite(8'h5A);
    t_in  = 8'h5A;
    tsent = 1'b1;
    cnt   = 0;
    while (fifo_we !== 1'b1 && cnt < 30) begin
      @(negedge clk);
      cnt++;
    end
    check("latency", cnt, 32'd4);
    tsent = 1'b0;
    waitTrecieve(1'b0, 20, "single_ack_fall");
    check("single_count", {22'h0, byte_count}, 32'd1);
`ifdef BETWEEN_TO_FIFO_CRC_EN
    check("single_crc", {24'h0, crc}, 32'h81);
`endif

    // Three-byte frame ending in the terminator
    doReset();
    sendByte(8'h31);
    sendByte(8'h32);
    check("mid_finish", {31'h0, isFinish}, 32'd0);
    sendByte(8'h0A);
    check("frame_finish", {31'h0, isFinish}, 32'd1);
    check("frame_count", {22'h0, byte_count}, 32'd3);
    t_in  = 8'h44;
    tsent = 1'b1;
    ackHi = 0;
    repeat (12) begin
      @(negedge clk);
      if (trecieve) ackHi++;
    end
    check("done_ignores_tsent", ackHi, 32'd0);
    tsent = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("clear_finish", {31'h0, isFinish}, 32'd0);
    check("clear_count", {22'h0, byte_count}, 32'd0);
    check("clear_crc", {24'h0, crc}, 32'd0);
    expCount = '0;
    expCrc   = 8'h00;
    enable   = 1'b1;
    repeat (2) @(negedge clk);

    // FIFO full backpressure
    fifo_full = 1'b1;
    expectWrite(8'h77);
    t_in  = 8'h77;
    tsent = 1'b1;
    ackHi = 0;
    weHi  = 0;
    repeat (20) begin
      @(negedge clk);
      if (trecieve) ackHi++;
      if (fifo_we) weHi++;
    end
    check("full_no_ack", ackHi, 32'd0);
    check("full_no_we", weHi, 32'd0);
    fifo_full = 1'b0;
    @(negedge clk);
    check("full_release_we", {31'h0, fifo_we}, 32'd1);
    check("full_release_ack", {31'h0, trecieve}, 32'd1);
    tsent = 1'b0;
    waitTrecieve(1'b0, 20, "full_ack_fall");
    @(negedge clk);

    // One-cycle tsent glitch
    expectWrite(8'hC3);
    t_in  = 8'hC3;
    tsent = 1'b1;
    @(negedge clk);
    tsent = 1'b0;
    ackHi = 0;
    weHi  = 0;
    repeat (12) begin
      @(negedge clk);
      if (trecieve) ackHi++;
      if (fifo_we) weHi++;
    end
    check("glitch_ack_width", ackHi, 32'd1);
    check("glitch_we_count", weHi, 32'd1);
    check("glitch_proto", {31'h0, proto_err}, 32'd1);
    sendByte(8'h3C);
    check("proto_sticky", {31'h0, proto_err}, 32'd1);

    // Asynchronous reset while acknowledging
    expectWrite(8'h99);
    t_in  = 8'h99;
    tsent = 1'b1;
    waitTrecieve(1'b1, 60, "pre_reset_ack");
    #2;
    reset = 1'b1;
    #1;
    check("async_trecieve", {31'h0, trecieve}, 32'd0);
    check("async_we", {31'h0, fifo_we}, 32'd0);
    check("async_count", {22'h0, byte_count}, 32'd0);
    check("async_crc", {24'h0, crc}, 32'd0);
    check("async_proto", {31'h0, proto_err}, 32'd0);
    doReset();

    // Byte counter saturation
    for (int i = 0; i < 1025; i++) sendByte(8'((i % 200) + 16));
    check("sat_count", {22'h0, byte_count}, 32'd1023);
    check("sat_finish", {31'h0, isFinish}, 32'd0);

    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
